acl_tx_retx_ctrl: RTL
=====================

ACL_TX_RETX_CTRL -- requirements
Module: acl_tx_retx_ctrl

Interface
REQ-001 clk_6M  input  1  6 MHz system clock; all state updates on rising edge.
REQ-002 rstz  input  1  reset, asynchronous, active-low.
REQ-003 ms_lt_addr  input  3  LT_ADDR of the link owning the current TX/RX slot pair; indexes all per-link state.
REQ-004 conns  input  1  connection state active; when 0, tx_start_p is ignored.
REQ-005 conn_new_p  input  1  new link setup pulse for ms_lt_addr.
REQ-006 tx_start_p  input  1  TX decision strobe, once per TX slot, before header encode.
REQ-007 rx_endp  input  1  RX slot end strobe.
REQ-008 rx_hdr_ok  input  1  response header valid (CAC, HEC, addressed) for ms_lt_addr at rx_endp.
REQ-009 dec_arqn_bit, dec_flow_bit  input  1 each  received ARQN and FLOW for ms_lt_addr.
REQ-010 mcu_load_p  input  1  MCU has written a payload for ms_lt_addr.
REQ-011 mcu_pktype  input  4  packet type of the loaded payload.
REQ-012 mcu_flush_p  input  1  discard pending payload of ms_lt_addr.
REQ-013 regi_maxretry  input  8  maximum retransmissions; 0 = unlimited.
REQ-014 send_new, send_old, send_null  output  1 each  registered one-cycle TX decision pulses.
REQ-015 tx_pktype  output  4  packet type to encode; 4'h0 (NULL) with send_null.
REQ-016 txSEQN  output  8  per-link SEQN bits.
REQ-017 buf_free  output  1  buffer of ms_lt_addr is EMPTY.
REQ-018 retx_cnt  output  8  retry count of ms_lt_addr.
REQ-019 ack_p, drop_p, flush_done_p, load_err_p  output  1 each  one-cycle event pulses.

Function
REQ-020 Per-link state, 8 entries: st{EMPTY, READY, INFLIGHT}, pktype[3:0], retry[7:0], SEQN bit.
REQ-021 Event priority per cycle: conn_new_p > mcu_flush_p > rx_endp > tx_start_p > mcu_load_p.
REQ-022 conn_new_p: entry -> EMPTY, SEQN=1, retry=0; other entries untouched.
REQ-023 EMPTY + mcu_load_p: -> READY, pktype captured; mcu_load_p in READY/INFLIGHT is ignored and pulses load_err_p.
REQ-024 EMPTY + tx_start_p: send_null.
REQ-025 READY + tx_start_p + dec_flow_bit=1: -> INFLIGHT, send_new, tx_pktype=stored pktype, SEQN toggles, retry=0.
REQ-026 Any state + tx_start_p + dec_flow_bit=0: send_null, state and retry unchanged.
REQ-027 INFLIGHT + tx_start_p + flow=1, retry < maxretry or maxretry=0: send_old, same SEQN, retry+1 saturating at 255.
REQ-028 INFLIGHT + tx_start_p + flow=1, maxretry!=0 and retry==maxretry: -> EMPTY, drop_p, send_null.
REQ-029 INFLIGHT + rx_endp + rx_hdr_ok + dec_arqn_bit=1: -> EMPTY, ack_p, retry=0.
REQ-030 INFLIGHT + rx_endp with rx_hdr_ok=0 or ARQN=0: stays INFLIGHT; retransmitted at next tx_start_p.
REQ-031 rx_endp in EMPTY/READY: no effect.
REQ-032 mcu_flush_p: -> EMPTY, retry=0, flush_done_p; SEQN kept. Coincident tx_start_p yields send_null.
REQ-033 rx_endp ACK coincident with tx_start_p: ACK applied first; TX decision uses EMPTY -> send_null.
REQ-034 conns=0: tx_start_p produces no pulse and no state change.
REQ-035 Exactly one of send_new/send_old/send_null pulses per accepted tx_start_p, one cycle later; tx_pktype held until next decision.
REQ-036 buf_free and retx_cnt are combinational from the ms_lt_addr entry.

Reset
REQ-037 rstz low: all entries EMPTY, retry=0, txSEQN=8'hff, tx_pktype=0, all pulses 0; asynchronous, mid-operation included.

Verification
REQ-038 Load DM1 (4'h3) on LT 1, tx_start_p flow=1 -> send_new, tx_pktype=3, txSEQN[1] 1->0; rx_endp ARQN=1 -> ack_p, buf_free=1.
REQ-039 maxretry=2, NAK every slot -> send_new, send_old, send_old (retx_cnt=2), then drop_p + send_null, entry EMPTY.
REQ-040 INFLIGHT, dec_flow_bit=0 at tx_start_p -> send_null, retx_cnt unchanged; flow=1 -> send_old.
REQ-041 Flush coincident with tx_start_p on READY link -> send_null, flush_done_p, txSEQN unchanged; then load -> load_err_p=0.
REQ-042 Load LT 2 while LT 2 INFLIGHT -> load_err_p, pktype unchanged; conn_new_p on LT 2 -> EMPTY, txSEQN[2]=1, other links intact.
REQ-043 rstz asserted while INFLIGHT with retry=5 -> all outputs at reset values immediately, txSEQN=8'hff.

Source files
------------

// File: rtl/acl_tx_retx_ctrl.sv
// rtl/acl_tx_retx_ctrl.sv - per-link ACL TX buffer, ARQ retransmission and SEQN controller
module acl_tx_retx_ctrl (
    input  logic       clk_6M,
    input  logic       rstz,
    input  logic [2:0] ms_lt_addr,
    input  logic       conns,
    input  logic       conn_new_p,
    input  logic       tx_start_p,
    input  logic       rx_endp,
    input  logic       rx_hdr_ok,
    input  logic       dec_arqn_bit,
    input  logic       dec_flow_bit,
    input  logic       mcu_load_p,
    input  logic [3:0] mcu_pktype,
    input  logic       mcu_flush_p,
    input  logic [7:0] regi_maxretry,
    output logic       send_new,
    output logic       send_old,
    output logic       send_null,
    output logic [3:0] tx_pktype,
    output logic [7:0] txSEQN,
    output logic       buf_free,
    output logic [7:0] retx_cnt,
    output logic       ack_p,
    output logic       drop_p,
    output logic       flush_done_p,
    output logic       load_err_p
);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_READY    = 2'd1,
        ST_INFLIGHT = 2'd2
    } link_st_e;

    localparam logic [3:0] PKT_NULL = 4'h0;

    link_st_e   st_q     [8];
    logic [3:0] pktype_q [8];
    logic [7:0] retry_q  [8];
    logic [7:0] seqn_q;

    // Current entry as seen at the start of the cycle
    link_st_e   cur_st;
    logic [3:0] cur_pktype;
    logic [7:0] cur_retry;
    logic       cur_seqn;

    // Next values for the addressed entry and registered outputs
    link_st_e   n_st;
    logic [3:0] n_pktype;
    logic [7:0] n_retry;
    logic       n_seqn;
    logic [3:0] n_tx_pktype;
    logic       n_send_new;
    logic       n_send_old;
    logic       n_send_null;
    logic       n_ack;
    logic       n_drop;
    logic       n_flush_done;
    logic       n_load_err;

    assign cur_st     = st_q[ms_lt_addr];
    assign cur_pktype = pktype_q[ms_lt_addr];
    assign cur_retry  = retry_q[ms_lt_addr];
    assign cur_seqn   = seqn_q[ms_lt_addr];

    assign txSEQN   = seqn_q;
    assign buf_free = (cur_st == ST_EMPTY);
    assign retx_cnt = cur_retry;

    // Apply the cycle's events to the addressed entry in priority order; each
    // later event sees the state left by the earlier ones (ACK before TX, etc.)
    always_comb begin
        n_st         = cur_st;
        n_pktype     = cur_pktype;
        n_retry      = cur_retry;
        n_seqn       = cur_seqn;
        n_tx_pktype  = tx_pktype;
        n_send_new   = 1'b0;
        n_send_old   = 1'b0;
        n_send_null  = 1'b0;
        n_ack        = 1'b0;
        n_drop       = 1'b0;
        n_flush_done = 1'b0;
        n_load_err   = 1'b0;

        if (conn_new_p) begin
            // A fresh link owns the entry outright; nothing else this cycle applies
            n_st    = ST_EMPTY;
            n_seqn  = 1'b1;
            n_retry = 8'd0;
        end else begin
            if (mcu_flush_p) begin
                n_st         = ST_EMPTY;
                n_retry      = 8'd0;
                n_flush_done = 1'b1;
            end else if (rx_endp && (n_st == ST_INFLIGHT) && rx_hdr_ok && dec_arqn_bit) begin
                n_st    = ST_EMPTY;
                n_retry = 8'd0;
                n_ack   = 1'b1;
            end

            if (tx_start_p && conns) begin
                if (!dec_flow_bit || (n_st == ST_EMPTY)) begin
                    n_send_null = 1'b1;
                    n_tx_pktype = PKT_NULL;
                end else if (n_st == ST_READY) begin
                    n_st        = ST_INFLIGHT;
                    n_send_new  = 1'b1;
                    n_tx_pktype = n_pktype;
                    n_seqn      = ~n_seqn;
                    n_retry     = 8'd0;
                end else if ((regi_maxretry == 8'd0) || (n_retry < regi_maxretry)) begin
                    n_send_old  = 1'b1;
                    n_tx_pktype = n_pktype;
                    n_retry     = (n_retry == 8'hff) ? 8'hff : n_retry + 8'd1;
                end else begin
                    // Retry budget exhausted: give the slot away and free the buffer
                    n_st        = ST_EMPTY;
                    n_retry     = 8'd0;
                    n_drop      = 1'b1;
                    n_send_null = 1'b1;
                    n_tx_pktype = PKT_NULL;
                end
            end

            // A flush in the same cycle wins over a load; otherwise load sees the
            // state after RX/TX handling
            if (mcu_load_p && !mcu_flush_p) begin
                if (n_st == ST_EMPTY) begin
                    n_st     = ST_READY;
                    n_pktype = mcu_pktype;
                end else begin
                    n_load_err = 1'b1;
                end
            end
        end
    end

    // Per-link state and registered decision/event pulses
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < 8; i++) begin
                st_q[i]     <= ST_EMPTY;
                pktype_q[i] <= 4'h0;
                retry_q[i]  <= 8'd0;
            end
            seqn_q       <= 8'hff;
            tx_pktype    <= PKT_NULL;
            send_new     <= 1'b0;
            send_old     <= 1'b0;
            send_null    <= 1'b0;
            ack_p        <= 1'b0;
            drop_p       <= 1'b0;
            flush_done_p <= 1'b0;
            load_err_p   <= 1'b0;
        end else begin
            st_q[ms_lt_addr]     <= n_st;
            pktype_q[ms_lt_addr] <= n_pktype;
            retry_q[ms_lt_addr]  <= n_retry;
            seqn_q[ms_lt_addr]   <= n_seqn;
            tx_pktype            <= n_tx_pktype;
            send_new             <= n_send_new;
            send_old             <= n_send_old;
            send_null            <= n_send_null;
            ack_p                <= n_ack;
            drop_p               <= n_drop;
            flush_done_p         <= n_flush_done;
            load_err_p           <= n_load_err;
        end
    end

endmodule
